imem_writer: RTL

//   Loads a program image into instruction memory. Accepts a byte stream over a

---
 rtl/imem_writer_if.sv | 27 ++
 rtl/imem_writer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/imem_writer_if.sv
// Byte-stream loader bus: byte handshake in, instruction RAM write port and load status out.
interface imem_writer_if #(
  parameter int WORD_SIZE = 32
);
  logic                 start;
  logic [31:0]          word_count;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 cpu_hold;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
  );
endinterface

// File: rtl/imem_writer.sv
// Assembles a little-endian byte stream into words and writes them to instruction RAM,
// holding the CPU in reset until the image is loaded. Optional trailing checksum: IMEM_WRITER_CHECKSUM_EN.
module imem_writer #(
  parameter int SIZE      = 256,
  parameter int WORD_SIZE = 32
) (
  input logic           clk,
  input logic           rst_n,
  imem_writer_if.slave  bus
);

  localparam int BPW   = WORD_SIZE / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
`ifdef IMEM_WRITER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [31:0]      words_q;
  logic             accept;
  logic             last_word;

  assign accept    = bus.byte_valid && bus.byte_ready;
  assign last_word = (bus.mem_addr == words_q - 32'd1);

`ifdef IMEM_WRITER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_next;
  assign sum_next = sum_q + bus.byte_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      words_q        <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.cpu_hold   <= 1'b1;
`ifdef IMEM_WRITER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            words_q      <= bus.word_count;
            bus.mem_addr <= '0;
            byte_cnt     <= '0;
            bus.error    <= 1'b0;
            bus.cpu_hold <= 1'b1;
`ifdef IMEM_WRITER_CHECKSUM_EN
            sum_q        <= '0;
`endif
            // Empty and oversized images finish on the start edge itself.
            if (bus.word_count == 32'd0) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.busy     <= 1'b0;
              bus.cpu_hold <= 1'b0;
            end else if (bus.word_count > 32'(SIZE)) begin
              state     <= DONE;
              bus.done  <= 1'b1;
              bus.busy  <= 1'b0;
              bus.error <= 1'b1;
            end else begin
              state          <= COLLECT;
              bus.done       <= 1'b0;
              bus.busy       <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            for (int k = 0; k < BPW; k++) begin
              if (byte_cnt == CNT_W'(k)) bus.mem_wdata[8*k +: 8] <= bus.byte_in;
            end
`ifdef IMEM_WRITER_CHECKSUM_EN
            sum_q <= sum_next;
`endif
            if (byte_cnt == CNT_W'(BPW - 1)) begin
              state          <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.mem_we     <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          bus.mem_we <= 1'b0;
          if (last_word) begin
`ifdef IMEM_WRITER_CHECKSUM_EN
            state          <= CHECK;
            bus.byte_ready <= 1'b1;
`else
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.cpu_hold <= 1'b0;
`endif
          end else begin
            state          <= COLLECT;
            bus.mem_addr   <= bus.mem_addr + 32'd1;
            byte_cnt       <= '0;
            bus.byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_WRITER_CHECKSUM_EN
        // The checksum byte makes the running byte sum wrap to zero on a good image.
        CHECK: begin
          if (accept) begin
            state          <= DONE;
            bus.byte_ready <= 1'b0;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            bus.error      <= (sum_next != 8'd0);
            bus.cpu_hold   <= (sum_next != 8'd0);
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
